// File: rtl/music_score_recorder.sv
// music_score_recorder
// Turns live key input, sampled once per 1 ms tick, into a sequence of
// 24-bit score entries {length[15:0], note[3:0], octave[3:0]}. Each
// entry is written to the score RAM write port starting at address 0.
// Each run of an identical {note, octave} pair becomes one entry, and a
// run that reaches 16'hFFFF is split into a second entry.
//
// Optional feature macro: MUSIC_SCORE_TERMINATOR_EN
//   defined   : a zero entry is written after the last note, capacity DEPTH-1
//   undefined : no terminator is written, capacity DEPTH
//
// State table
//   IDLE | waiting for en; outputs hold the last session's results
//   REC  | measuring the held pair, flushing an entry on change/saturation
//   TERM | writing the zero terminator entry
//   DONE | session finished; waits for en low before returning to IDLE
module music_score_recorder #(
    parameter int DEPTH = 256
) (
    input  logic        clk_1ms,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  key_note,
    input  logic [3:0]  key_octave,
    output logic        we,
    output logic [7:0]  wr_addr,
    output logic [23:0] wr_data,
    output logic [7:0]  note_count,
    output logic [15:0] cur_length,
    output logic        busy,
    output logic        full
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_TERM = 2'd2,
        S_DONE = 2'd3
    } state_t;

`ifdef MUSIC_SCORE_TERMINATOR_EN
    localparam int     CAP      = DEPTH - 1;
    localparam state_t END_ST   = S_TERM;
    localparam logic   END_BUSY = 1'b1;
`else
    localparam int     CAP      = DEPTH;
    localparam state_t END_ST   = S_DONE;
    localparam logic   END_BUSY = 1'b0;
`endif

    // Nine bits so a capacity of 256 entries can be compared without wrapping.
    localparam logic [8:0] CAP_C = 9'(CAP);

    state_t       state_q;
    logic [3:0]   held_note_q;
    logic [3:0]   held_oct_q;
    logic [7:0]   ptr_q;
    logic [8:0]   count_q;
    logic [15:0]  len_q;
    logic         we_q;
    logic [7:0]   wr_addr_q;
    logic [23:0]  wr_data_q;
    logic         busy_q;
    logic         full_q;

    logic         key_chg;
    logic         len_sat;
    logic [8:0]   count_d;
    logic [23:0]  entry_d;

    // Flush conditions and the entry that a flush would write this cycle.
    always_comb begin
        key_chg = {key_note, key_octave} != {held_note_q, held_oct_q};
        len_sat = (len_q == 16'hFFFF);
        count_d = count_q + 9'd1;
        entry_d = {len_q, held_note_q, held_oct_q};
    end

    // Recording FSM; all outputs are registered here.
    always_ff @(posedge clk_1ms or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            held_note_q <= 4'd0;
            held_oct_q  <= 4'd0;
            ptr_q       <= 8'd0;
            count_q     <= 9'd0;
            len_q       <= 16'd0;
            we_q        <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 24'd0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        count_q     <= 9'd0;
                        ptr_q       <= 8'd0;
                        wr_addr_q   <= 8'd0;
                        full_q      <= 1'b0;
                        held_note_q <= key_note;
                        held_oct_q  <= key_octave;
                        len_q       <= 16'd1;
                        busy_q      <= 1'b1;
                        state_q     <= S_REC;
                    end
                end
                S_REC: begin
                    if (!en) begin
                        // A key change in the same cycle is ignored: flush only.
                        we_q      <= 1'b1;
                        wr_addr_q <= ptr_q;
                        wr_data_q <= entry_d;
                        ptr_q     <= ptr_q + 8'd1;
                        count_q   <= count_d;
                        busy_q    <= END_BUSY;
                        state_q   <= END_ST;
                    end else if (key_chg || len_sat) begin
                        // Saturated runs restart as a new entry with the same pair.
                        we_q        <= 1'b1;
                        wr_addr_q   <= ptr_q;
                        wr_data_q   <= entry_d;
                        ptr_q       <= ptr_q + 8'd1;
                        count_q     <= count_d;
                        held_note_q <= key_note;
                        held_oct_q  <= key_octave;
                        len_q       <= 16'd1;
                        if (count_d == CAP_C) begin
                            full_q  <= 1'b1;
                            busy_q  <= END_BUSY;
                            state_q <= END_ST;
                        end
                    end else begin
                        len_q <= len_q + 16'd1;
                    end
                end
                S_TERM: begin
                    we_q      <= 1'b1;
                    wr_addr_q <= ptr_q;
                    wr_data_q <= 24'h000000;
                    busy_q    <= 1'b0;
                    state_q   <= S_DONE;
                end
                S_DONE: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign we         = we_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign note_count = count_q[7:0];
    assign cur_length = len_q;
    assign busy       = busy_q;
    assign full       = full_q;

endmodule

// File: tb/tb_music_score_recorder.sv
// Directed bench for music_score_recorder: a 256-deep and a 4-deep instance.
// Expected writes are queued as {addr, data} when stimulus is applied and
// popped by a per-instance write monitor whenever we=1.
module tb_music_score_recorder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        b_en = 1'b0, s_en = 1'b0;
    logic [3:0]  b_note = 4'd0, b_oct = 4'd0, s_note = 4'd0, s_oct = 4'd0;
    logic        b_we, s_we, b_busy, s_busy, b_full, s_full;
    logic [7:0]  b_addr, s_addr, b_cnt, s_cnt;
    logic [23:0] b_data, s_data;
    logic [15:0] b_len, s_len;

    int errs   = 0;
    int checks = 0;

    logic [31:0] b_exp[$];
    logic [31:0] s_exp[$];

`ifdef MUSIC_SCORE_TERMINATOR_EN
    localparam bit TERM = 1'b1;
`else
    localparam bit TERM = 1'b0;
`endif

    always #5 clk = ~clk;

    music_score_recorder #(.DEPTH(256)) u_big (
        .clk_1ms(clk), .rst(rst), .en(b_en), .key_note(b_note), .key_octave(b_oct),
        .we(b_we), .wr_addr(b_addr), .wr_data(b_data), .note_count(b_cnt),
        .cur_length(b_len), .busy(b_busy), .full(b_full)
    );

    music_score_recorder #(.DEPTH(4)) u_small (
        .clk_1ms(clk), .rst(rst), .en(s_en), .key_note(s_note), .key_octave(s_oct),
        .we(s_we), .wr_addr(s_addr), .wr_data(s_data), .note_count(s_cnt),
        .cur_length(s_len), .busy(s_busy), .full(s_full)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitors: every strobe must match the next queued entry.
    always @(negedge clk) begin
        if (b_we === 1'b1) begin
            if (b_exp.size() == 0) chk("big_unexpected_write", {b_addr, b_data}, 32'hFFFF_FFFF);
            else chk("big_write", {b_addr, b_data}, b_exp.pop_front());
        end
        if (s_we === 1'b1) begin
            if (s_exp.size() == 0) chk("small_unexpected_write", {s_addr, s_data}, 32'hFFFF_FFFF);
            else chk("small_write", {s_addr, s_data}, s_exp.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("reset_outputs", {b_we, b_addr, b_data, b_cnt, b_len, b_busy, b_full}, 64'd0);
        rst = 1'b0;
        cyc(2);

        // Basic two-note session: (5,4) x3, (7,4) x2, en low
        b_exp.push_back({8'd0, 24'h000354});
        b_exp.push_back({8'd1, 24'h000274});
        if (TERM) b_exp.push_back({8'd2, 24'h000000});
        b_en = 1'b1; b_note = 4'd5; b_oct = 4'd4;
        cyc(1);
        chk("start_len", b_len, 16'd1);
        chk("start_busy", b_busy, 1'b1);
        cyc(2);
        chk("run_len3", b_len, 16'd3);
        b_note = 4'd7;
        cyc(1);
        chk("flush_we", b_we, 1'b1);
        chk("new_len1", b_len, 16'd1);
        cyc(1);
        b_en = 1'b0;
        cyc(4);
        chk("basic_count", b_cnt, 8'd2);
        chk("basic_full", b_full, 1'b0);
        chk("basic_busy", b_busy, 1'b0);
        chk("basic_pending", b_exp.size(), 0);

        // Rests and octave changes: (0,4) x2, (0,5) x1
        b_exp.push_back({8'd0, 24'h000204});
        b_exp.push_back({8'd1, 24'h000105});
        if (TERM) b_exp.push_back({8'd2, 24'h000000});
        b_en = 1'b1; b_note = 4'd0; b_oct = 4'd4;
        cyc(2);
        b_oct = 4'd5;
        cyc(1);
        b_en = 1'b0;
        cyc(4);
        chk("rest_pending", b_exp.size(), 0);

        // Key change coinciding with en falling: only the old pair is flushed
        b_exp.push_back({8'd0, 24'h000232});
        if (TERM) b_exp.push_back({8'd1, 24'h000000});
        b_en = 1'b1; b_note = 4'd3; b_oct = 4'd2;
        cyc(2);
        b_en = 1'b0; b_note = 4'd9; b_oct = 4'd1;
        cyc(4);
        chk("fall_pending", b_exp.size(), 0);
        chk("fall_count", b_cnt, 8'd1);

        // Saturation: (1,3) for 65537 cycles
        b_exp.push_back({8'd0, 24'hFFFF13});
        b_exp.push_back({8'd1, 24'h000213});
        if (TERM) b_exp.push_back({8'd2, 24'h000000});
        b_en = 1'b1; b_note = 4'd1; b_oct = 4'd3;
        cyc(65535);
        chk("sat_len_max", b_len, 16'hFFFF);
        cyc(1);
        chk("sat_len_wrap", b_len, 16'd1);
        cyc(1);
        b_en = 1'b0;
        cyc(4);
        chk("sat_pending", b_exp.size(), 0);
        chk("sat_count", b_cnt, 8'd2);

        // Reset mid-REC after 10 cycles of (2,5): no write may appear
        b_en = 1'b1; b_note = 4'd2; b_oct = 4'd5;
        cyc(10);
        chk("pre_reset_len", b_len, 16'd10);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", {b_we, b_addr, b_data, b_cnt, b_len, b_busy, b_full}, 64'd0);
        b_en = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(3);
        chk("post_reset_busy", b_busy, 1'b0);
        chk("post_reset_len", b_len, 16'd0);

        // DEPTH=4: change key every cycle until full
        s_exp.push_back({8'd0, 24'h000111});
        s_exp.push_back({8'd1, 24'h000121});
        s_exp.push_back({8'd2, 24'h000131});
        if (TERM) s_exp.push_back({8'd3, 24'h000000});
        else s_exp.push_back({8'd3, 24'h000141});
        s_en = 1'b1; s_oct = 4'd1;
        for (int i = 1; i <= 8; i++) begin
            s_note = 4'(i);
            cyc(1);
        end
        chk("small_full", s_full, 1'b1);
        chk("small_busy", s_busy, 1'b0);
        chk("small_count", s_cnt, TERM ? 8'd3 : 8'd4);
        chk("small_pending", s_exp.size(), 0);
        cyc(3);
        chk("small_done_hold_full", s_full, 1'b1);

        // en low then high: new session starts at address 0
        s_en = 1'b0;
        cyc(2);
        chk("small_full_readable", s_full, 1'b1);
        s_exp.push_back({8'd0, 24'h000222});
        if (TERM) s_exp.push_back({8'd1, 24'h000000});
        s_en = 1'b1; s_note = 4'd2; s_oct = 4'd2;
        cyc(1);
        chk("restart_full_clr", s_full, 1'b0);
        chk("restart_count_clr", s_cnt, 8'd0);
        cyc(1);
        s_en = 1'b0;
        cyc(4);
        chk("restart_pending", s_exp.size(), 0);
        chk("restart_count", s_cnt, 8'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
